// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 8N1 UART receiver with start-bit validation, framing-error
// detection, sticky error flags and a show-ahead receive FIFO.
module uart_rx_engine #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [15:0]                  clock_divider,
  input  logic                         rx,
  input  logic                         read_en,
  input  logic                         clear_errors,
  output logic [7:0]                   data_out,
  output logic                         data_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         framing_error,
  output logic                         overrun,
  output logic                         busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Synchronizer and edge-detect history
  logic              rx_meta;
  logic              rxs;
  logic              rxs_prev;

  // Receive state machine
  state_t            state;
  state_t            state_nxt;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_nxt;
  logic [DIV_W-1:0]  cyc_cnt;
  logic [DIV_W-1:0]  cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] shift_nxt;
  logic [DIV_W-1:0]  target;
  logic              cnt_hit;
  logic              push_req;
  logic              frame_err;

  // FIFO
  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_nxt;
  logic [PTR_W-1:0]  rd_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [BYTE_W-1:0] head_nxt;
  logic              fifo_full;
  logic              do_push;
  logic              do_pop;
  logic              ovr_evt;

  // Two-flop synchronizer on rx, idling high, plus one cycle of history for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Receive FSM state and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      div_q   <= '0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_nxt;
      div_q   <= div_nxt;
      cyc_cnt <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift_q <= shift_nxt;
    end
  end

  // Half-bit wait for the start check, full-bit wait otherwise
  always_comb begin
    target  = div_q;
    if (state == ST_START) begin
      target = {1'b0, div_q[DIV_W-1:1]};
    end
    cnt_hit = (cyc_cnt == (target - DIV_W'(1)));
  end

  // Receive FSM next-state: start validation, data shifting, stop check, break wait
  always_comb begin
    state_nxt = state;
    div_nxt   = div_q;
    cnt_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rxs_prev && !rxs) begin
          div_nxt   = clock_divider;
          cnt_nxt   = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (cnt_hit) begin
          cnt_nxt = '0;
          bit_nxt = '0;
          if (rxs) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          cnt_nxt = cyc_cnt + DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_hit) begin
          cnt_nxt   = '0;
          shift_nxt = {rxs, shift_q[BYTE_W-1:1]};
          bit_nxt   = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(7)) begin
            state_nxt = ST_STOP;
          end
        end else begin
          cnt_nxt = cyc_cnt + DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_hit) begin
          cnt_nxt = '0;
          if (rxs) begin
            push_req  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = ST_BREAK;
          end
        end else begin
          cnt_nxt = cyc_cnt + DIV_W'(1);
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs
  always_comb begin
    fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    do_pop    = read_en && (fifo_count != '0);
    do_push   = push_req && (!fifo_full || do_pop);
    ovr_evt   = push_req && fifo_full && !read_en;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    count_nxt = fifo_count;
    if (do_push) begin
      wr_nxt = wr_ptr + PTR_W'(1);
    end
    if (do_pop) begin
      rd_nxt = rd_ptr + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // Next head value, taking the byte being written when it becomes the head
  always_comb begin
    head_nxt = mem[rd_nxt];
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (do_push && (wr_ptr == rd_nxt)) begin
      head_nxt = shift_q;
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= shift_q;
    end
  end

  // FIFO pointers, count and registered head/status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      fifo_count <= count_nxt;
      data_out   <= head_nxt;
      data_ready <= (count_nxt != '0);
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Sticky error flags; a new error event wins over a clear in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (frame_err) begin
        framing_error <= 1'b1;
      end else if (clear_errors) begin
        framing_error <= 1'b0;
      end
      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (clear_errors) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Testbench for uart_rx_engine: directed frame table, timed corner-case
// sequences, and randomized frames checked against a queue-based model.
module tb_uart_rx_engine;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic [15:0] clock_divider;
  logic        rx;
  logic        read_en;
  logic        clear_errors;
  logic [7:0]  data_out;
  logic        data_ready;
  logic [2:0]  fifo_count;
  logic        framing_error;
  logic        overrun;
  logic        busy;

  int n_cmp;
  int n_err;

  uart_rx_engine #(.FIFO_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clock_divider (clock_divider),
    .rx            (rx),
    .read_en       (read_en),
    .clear_errors  (clear_errors),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .fifo_count    (fifo_count),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         send;
    logic [7:0] data;
    bit         stop_ok;
    int         pops;
    bit         clr;
    int         exp_count;
    logic [7:0] exp_head;
    bit         exp_fe;
    bit         exp_ov;
  } vec_t;

  vec_t vecs [15];

  // Reference model state for the randomized phase
  logic [7:0] mq [$];
  bit         m_fe;
  bit         m_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one 8N1 frame; first posedge inside is cycle 0 of the frame
  task automatic send_frame(input logic [7:0] d, input bit ok, input int div,
                            input int extra_low, input bit scramble);
    @(posedge clock);
    #1;
    clock_divider = 16'(div);
    rx = 1'b0;
    tick(div);
    if (scramble) clock_divider = 16'($urandom_range(4, 60));
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(div);
    end
    rx = ok;
    tick(div);
    if (!ok) begin
      tick(extra_low);
      rx = 1'b1;
      tick(div);
    end
  endtask

  task automatic pop_one();
    @(posedge clock);
    #1 read_en = 1'b1;
    @(posedge clock);
    #1 read_en = 1'b0;
  endtask

  task automatic clear_pulse();
    @(posedge clock);
    #1 clear_errors = 1'b1;
    @(posedge clock);
    #1 clear_errors = 1'b0;
  endtask

  task automatic check_state(input string tag, input int cnt, input logic [7:0] head,
                             input bit fe, input bit ov);
    chk({tag, "_count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, "_head"}, 32'(data_out), 32'(head));
    chk({tag, "_ready"}, 32'(data_ready), 32'(cnt != 0));
    chk({tag, "_ferr"}, 32'(framing_error), 32'(fe));
    chk({tag, "_ovr"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    int busy_cycles;
    int first_busy;
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    rx = 1'b1;
    read_en = 1'b0;
    clear_errors = 1'b0;
    clock_divider = 16'd16;

    // Directed frame table at divider 16
    vecs[0]  = '{1, 8'h55, 1, 0, 0, 1, 8'h55, 0, 0};
    vecs[1]  = '{1, 8'hA3, 1, 0, 0, 2, 8'h55, 0, 0};
    vecs[2]  = '{0, 8'h00, 1, 1, 0, 1, 8'hA3, 0, 0};
    vecs[3]  = '{1, 8'h41, 0, 0, 0, 1, 8'hA3, 1, 0};
    vecs[4]  = '{1, 8'h42, 1, 0, 0, 2, 8'hA3, 1, 0};
    vecs[5]  = '{0, 8'h00, 1, 2, 1, 0, 8'h00, 0, 0};
    vecs[6]  = '{1, 8'h10, 1, 0, 0, 1, 8'h10, 0, 0};
    vecs[7]  = '{1, 8'h11, 1, 0, 0, 2, 8'h10, 0, 0};
    vecs[8]  = '{1, 8'h12, 1, 0, 0, 3, 8'h10, 0, 0};
    vecs[9]  = '{1, 8'h13, 1, 0, 0, 4, 8'h10, 0, 0};
    vecs[10] = '{1, 8'h14, 1, 0, 0, 4, 8'h10, 0, 1};
    vecs[11] = '{0, 8'h00, 1, 1, 0, 3, 8'h11, 0, 1};
    vecs[12] = '{0, 8'h00, 1, 1, 0, 2, 8'h12, 0, 1};
    vecs[13] = '{0, 8'h00, 1, 2, 1, 0, 8'h00, 0, 0};
    vecs[14] = '{0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0};

    tick(3);
    check_state("reset", 0, 8'h00, 0, 0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // Push timing: data_ready rises the cycle after the stop sample (cycle 154)
    fork
      send_frame(8'h55, 1, 16, 0, 0);
      begin
        @(posedge clock);
        repeat (154) @(posedge clock);
        #1;
        chk("pre_push_ready", 32'(data_ready), 32'd0);
        chk("pre_push_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        chk("push_ready", 32'(data_ready), 32'd1);
        chk("push_head", 32'(data_out), 32'h55);
        chk("push_busy", 32'(busy), 32'd0);
      end
    join
    send_frame(8'hA3, 1, 16, 0, 0);
    tick(2);
    check_state("b2b", 2, 8'h55, 0, 0);
    pop_one();
    check_state("b2b_pop", 1, 8'hA3, 0, 0);
    pop_one();
    check_state("b2b_empty", 0, 8'h00, 0, 0);

    // 4-cycle low glitch: false start, busy high for exactly 8 cycles
    busy_cycles = 0;
    first_busy = -1;
    @(posedge clock);
    for (int i = 0; i < 40; i++) begin
      #1;
      rx = (i < 4) ? 1'b0 : 1'b1;
      if (busy) begin
        busy_cycles++;
        if (first_busy < 0) first_busy = i;
      end
      @(posedge clock);
    end
    #1;
    chk("glitch_busy_len", 32'(busy_cycles), 32'd8);
    chk("glitch_busy_start", 32'(first_busy), 32'd3);
    check_state("glitch", 0, 8'h00, 0, 0);

    // Table-driven frames
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].send) begin
        send_frame(vecs[v].data, vecs[v].stop_ok, 16, 40, 0);
        tick(3);
      end
      for (int p = 0; p < vecs[v].pops; p++) pop_one();
      if (vecs[v].clr) clear_pulse();
      check_state($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_head,
                  vecs[v].exp_fe, vecs[v].exp_ov);
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
    end

    // Full FIFO with read_en on the 5th push cycle: no overrun, bytes 2..5 kept
    for (int b = 0; b < 4; b++) send_frame(8'(8'h21 + b), 1, 16, 0, 0);
    fork
      send_frame(8'h25, 1, 16, 0, 0);
      begin
        @(posedge clock);
        repeat (154) @(posedge clock);
        #1 read_en = 1'b1;
        @(posedge clock);
        #1 read_en = 1'b0;
        chk("pushpop_count", 32'(fifo_count), 32'd4);
        chk("pushpop_ovr", 32'(overrun), 32'd0);
      end
    join
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("pushpop_head%0d", b), 32'(data_out), 32'(8'h22 + b));
      pop_one();
    end
    check_state("pushpop_empty", 0, 8'h00, 0, 0);

    // Reset mid-DATA with a non-empty FIFO and a set flag, released in the stop bit
    send_frame(8'h13, 0, 16, 5, 0);
    send_frame(8'h66, 1, 16, 0, 0);
    tick(2);
    check_state("prereset", 1, 8'h66, 1, 0);
    fork
      send_frame(8'h7E, 1, 16, 0, 0);
      begin
        @(posedge clock);
        repeat (60) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check_state("midreset", 0, 8'h00, 0, 0);
        chk("midreset_busy", 32'(busy), 32'd0);
        repeat (90) @(posedge clock);
        #1 reset_n = 1'b1;
      end
    join
    tick(20);
    check_state("postreset", 0, 8'h00, 0, 0);
    chk("postreset_busy", 32'(busy), 32'd0);

    // Framing error coinciding with clear_errors, line held low: one error only
    fork
      send_frame(8'h41, 0, 16, 40, 0);
      begin
        @(posedge clock);
        repeat (154) @(posedge clock);
        #1 clear_errors = 1'b1;
        @(posedge clock);
        #1 clear_errors = 1'b0;
        chk("clr_vs_ferr", 32'(framing_error), 32'd1);
        chk("clr_vs_ferr_count", 32'(fifo_count), 32'd0);
        tick(10);
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        chk("break_cleared", 32'(framing_error), 32'd0);
        chk("break_busy", 32'(busy), 32'd1);
      end
    join
    tick(5);
    chk("one_error_only", 32'(framing_error), 32'd0);
    send_frame(8'h42, 1, 16, 0, 0);
    tick(2);
    check_state("after_break", 1, 8'h42, 0, 0);
    pop_one();

    // Randomized frames against a queue model
    clear_pulse();
    mq.delete();
    m_fe = 0;
    m_ov = 0;
    check_state("rand_start", 0, 8'h00, 0, 0);
    for (int it = 0; it < 40; it++) begin
      logic [7:0] d;
      bit ok;
      int div;
      int npop;
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      div = $urandom_range(8, 24);
      send_frame(d, ok, div, ok ? 0 : $urandom_range(0, 30), 1'($urandom_range(0, 1)));
      if (ok) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ov = 1;
      end else begin
        m_fe = 1;
      end
      if ($urandom_range(0, 3) == 0) continue;
      tick(2);
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop_one();
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if ($urandom_range(0, 4) == 0) begin
        clear_pulse();
        m_fe = 0;
        m_ov = 0;
      end
      check_state($sformatf("rand%0d", it), mq.size(),
                  (mq.size() > 0) ? mq[0] : 8'h00, m_fe, m_ov);
    end
    tick(2);
    check_state("rand_end", mq.size(), (mq.size() > 0) ? mq[0] : 8'h00, m_fe, m_ov);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
